// File: rtl/pulse_cnt_scanner.sv
// pulse_cnt_scanner
//
// Snapshot-and-stream readout for the pulse counter array. A snapshot request
// in idle latches every channel count in one edge. The frozen set is then
// streamed one word per valid/ready transfer, and each word is tagged with
// its channel index.
//
// Optional feature: define PULSE_SCAN_CSUM_EN to append an XOR checksum word
// (tag CH_NUM, o_last set) after the channel words.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_pulse_cnt  flattened live counts, channel k at [k*CNT_W +: CNT_W]
//   i_snap       snapshot/readout request
//   i_ready      consumer accepts the current word when high with o_valid
//   o_valid      o_data/o_tag/o_last hold a word
//   o_data       captured count or checksum word
//   o_tag        channel index; CH_NUM marks the checksum word
//   o_last       final word of the frame
//   o_busy       frame in progress
//   o_done       one-cycle pulse after the final transfer
//   o_drop       one-cycle pulse: a request arrived while busy and was ignored
module pulse_cnt_scanner #(
  parameter int unsigned CH_NUM = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [CH_NUM*CNT_W-1:0] i_pulse_cnt,
  input  logic                    i_snap,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [CNT_W-1:0]        o_data,
  output logic [TAG_W-1:0]        o_tag,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_drop
);

  localparam int unsigned IdxW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CH_NUM - 1);

`ifdef PULSE_SCAN_CSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCsum, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  snap_q [CH_NUM];
  logic              capture;
  logic              xfer;

  // Registered outputs and their next-state values
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  assign xfer = valid_q & i_ready;

`ifdef PULSE_SCAN_CSUM_EN
  logic [CNT_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      csum = csum ^ snap_q[k];
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_snap) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        drop_d = i_snap;
        if (xfer) begin
          if (idx_q == IdxLast) begin
`ifdef PULSE_SCAN_CSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef PULSE_SCAN_CSUM_EN
      StCsum: begin
        drop_d = i_snap;
        if (xfer) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        drop_d  = i_snap;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    tag_d   = '0;
    last_d  = 1'b0;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    if (state_d == StSend) begin
      valid_d = 1'b1;
      tag_d   = TAG_W'(idx_d);
      // On the capture edge the snapshot is not yet loaded; channel 0 comes live.
      data_d  = capture ? i_pulse_cnt[CNT_W-1:0] : snap_q[idx_d];
`ifdef PULSE_SCAN_CSUM_EN
      last_d  = 1'b0;
`else
      last_d  = (idx_d == IdxLast);
`endif
    end
`ifdef PULSE_SCAN_CSUM_EN
    if (state_d == StCsum) begin
      valid_d = 1'b1;
      tag_d   = TAG_W'(CH_NUM);
      data_d  = csum;
      last_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      for (int k = 0; k < int'(CH_NUM); k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      if (capture) begin
        for (int k = 0; k < int'(CH_NUM); k++) begin
          snap_q[k] <= i_pulse_cnt[k*int'(CNT_W) +: CNT_W];
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_tag   = tag_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_pulse_cnt_scanner.sv
// Self-checking bench for pulse_cnt_scanner. Inputs are driven and outputs
// sampled on the falling edge. Expected frames come from a reference model
// that copies the live counts at request time.
module tb_pulse_cnt_scanner;

  localparam int CH_NUM = 16;
  localparam int CNT_W  = 16;
  localparam int TAG_W  = 5;
`ifdef PULSE_SCAN_CSUM_EN
  localparam int NW = CH_NUM + 1;
`else
  localparam int NW = CH_NUM;
`endif
  localparam int OW = 5 + TAG_W + CNT_W;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [CH_NUM*CNT_W-1:0] i_pulse_cnt;
  logic                    i_snap;
  logic                    i_ready;
  logic                    o_valid;
  logic [CNT_W-1:0]        o_data;
  logic [TAG_W-1:0]        o_tag;
  logic                    o_last;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_drop;

  always #5 i_clk = ~i_clk;

  pulse_cnt_scanner #(
    .CH_NUM (CH_NUM),
    .CNT_W  (CNT_W),
    .TAG_W  (TAG_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_pulse_cnt (i_pulse_cnt),
    .i_snap      (i_snap),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_tag       (o_tag),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_drop      (o_drop)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [CNT_W-1:0] live     [CH_NUM];
  logic [CNT_W-1:0] exp_data [NW];
  logic [TAG_W-1:0] exp_tag  [NW];
  logic             exp_last [NW];

  logic [OW-1:0] obs;
  logic [OW-1:0] expv;

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      i_pulse_cnt[k*CNT_W +: CNT_W] = live[k];
    end
  end

  // Observed outputs packed as {valid, busy, done, drop, last, tag, data}
  assign obs = {o_valid, o_busy, o_done, o_drop, o_last, o_tag, o_data};

  // Reference model: the frame is the live counts at request time, in
  // channel order, optionally followed by their XOR.
  task automatic model_capture();
    logic [CNT_W-1:0] x;
    x = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      exp_data[k] = live[k];
      exp_tag[k]  = TAG_W'(k);
      exp_last[k] = (k == CH_NUM - 1) && (NW == CH_NUM);
      x = x ^ live[k];
    end
`ifdef PULSE_SCAN_CSUM_EN
    exp_data[CH_NUM] = x;
    exp_tag[CH_NUM]  = TAG_W'(CH_NUM);
    exp_last[CH_NUM] = 1'b1;
`endif
  endtask

  function automatic logic [OW-1:0] frame_word(int w, logic drop);
    return {1'b1, 1'b1, 1'b0, drop, exp_last[w], exp_tag[w], exp_data[w]};
  endfunction

  function automatic logic [OW-1:0] idle_word(logic busy, logic done, logic drop);
    return {1'b0, busy, done, drop, 1'b0, TAG_W'(0), CNT_W'(0)};
  endfunction

  task automatic randomize_live();
    for (int k = 0; k < CH_NUM; k++) live[k] = CNT_W'($urandom);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_snap  = 1'b0;
    i_ready = 1'b0;
    randomize_live();
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_total++;
      if (obs !== '0) $display("FAIL reset_hold cyc %0d: got %h want 0", i, obs);
      else n_pass++;
      i_snap = i[0];
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_snap  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      n_total++;
      if (obs !== '0) $display("FAIL reset_idle cyc %0d: got %h want 0", i, obs);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < CH_NUM; k++) live[k] = CNT_W'(16'h1000 + k);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_snap = 1'b1;
    model_capture();
    for (int c = 1; c <= NW + 2; c++) begin
      @(negedge i_clk);
      i_snap = 1'b0;
      if (c <= NW)          expv = frame_word(c - 1, 1'b0);
      else if (c == NW + 1) expv = idle_word(1'b1, 1'b1, 1'b0);
      else                  expv = idle_word(1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL basic cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_frozen();
    randomize_live();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_snap = 1'b1;
    model_capture();
    for (int c = 1; c <= NW + 2; c++) begin
      @(negedge i_clk);
      i_snap = 1'b0;
      if (c <= NW)          expv = frame_word(c - 1, 1'b0);
      else if (c == NW + 1) expv = idle_word(1'b1, 1'b1, 1'b0);
      else                  expv = idle_word(1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL frozen cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
      if (c == 1) for (int k = 0; k < CH_NUM; k++) live[k] = 16'hFFFF;
      else if (c == 5) randomize_live();
    end
  endtask

  task automatic test_backpressure();
    int widx;
    int cyc;
    randomize_live();
    i_ready = 1'b0;
    @(negedge i_clk);
    i_snap = 1'b1;
    model_capture();
    widx = 0;
    cyc  = 0;
    while (widx < NW && cyc < 600) begin
      @(negedge i_clk);
      i_snap = 1'b0;
      cyc++;
      expv = frame_word(widx, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL backpressure word %0d cyc %0d: got %h want %h",
                                 widx, cyc, obs, expv);
      else n_pass++;
      i_ready = ($urandom_range(0, 2) == 0);
      if (i_ready) widx++;
    end
    n_total++;
    if (widx != NW) $display("FAIL backpressure_timeout: got %0d words want %0d", widx, NW);
    else n_pass++;
    @(negedge i_clk);
    i_ready = 1'b0;
    expv = idle_word(1'b1, 1'b1, 1'b0);
    n_total++;
    if (obs !== expv) $display("FAIL backpressure_done: got %h want %h", obs, expv);
    else n_pass++;
    @(negedge i_clk);
    expv = idle_word(1'b0, 1'b0, 1'b0);
    n_total++;
    if (obs !== expv) $display("FAIL backpressure_idle: got %h want %h", obs, expv);
    else n_pass++;
  endtask

  // Requests during word 5 and in the done cycle are dropped; a request in
  // the following idle cycle starts a second frame.
  task automatic test_drop();
    logic drop;
    randomize_live();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_snap = 1'b1;
    model_capture();
    for (int c = 1; c <= 2 * NW + 4; c++) begin
      @(negedge i_clk);
      drop = (c == 7) || (c == NW + 2);
      if (c <= NW)              expv = frame_word(c - 1, drop);
      else if (c == NW + 1)     expv = idle_word(1'b1, 1'b1, drop);
      else if (c == NW + 2)     expv = idle_word(1'b0, 1'b0, drop);
      else if (c <= 2 * NW + 2) expv = frame_word(c - NW - 3, 1'b0);
      else if (c == 2 * NW + 3) expv = idle_word(1'b1, 1'b1, 1'b0);
      else                      expv = idle_word(1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL drop cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
      i_snap = (c == 6) || (c == NW + 1) || (c == NW + 2);
      if (c == NW + 2) begin
        randomize_live();
        model_capture();
      end
    end
  endtask

  task automatic test_reset_mid();
    randomize_live();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_snap = 1'b1;
    model_capture();
    for (int c = 1; c <= 13; c++) begin
      @(negedge i_clk);
      if (c <= 9) expv = frame_word(c - 1, 1'b0);
      else        expv = idle_word(1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL reset_mid cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
      i_snap  = (c == 9);
      i_rst_n = (c != 9);
    end
    randomize_live();
    i_snap = 1'b1;
    model_capture();
    for (int c = 1; c <= NW + 2; c++) begin
      @(negedge i_clk);
      i_snap = 1'b0;
      if (c <= NW)          expv = frame_word(c - 1, 1'b0);
      else if (c == NW + 1) expv = idle_word(1'b1, 1'b1, 1'b0);
      else                  expv = idle_word(1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs !== expv) $display("FAIL reset_refill cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frozen();
    test_backpressure();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_cnt_scanner.md
# pulse_cnt_scanner

Readout stage that sits directly downstream of the sixteen-channel pulse detector/counter array. On a snapshot request it captures all sixteen 16-bit channel counts in one clock edge. It then streams them out one word per transfer over a valid/ready interface, tagged with the channel index, so a single narrow consumer (UART framer, bus bridge) can read a coherent set of counts while the counters keep running.

## Interface
Parameters:
- CH_NUM, 16, number of channels captured and streamed
- CNT_W, 16, width of each channel count and of o_data
- TAG_W, 5, width of o_tag; must satisfy 2^(TAG_W-1) >= CH_NUM

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_pulse_cnt  in  CH_NUM*CNT_W  flattened live counts; channel k at [k*CNT_W+CNT_W-1 : k*CNT_W]
- i_snap  in  1  snapshot/readout request, sampled each cycle
- i_ready  in  1  consumer accepts o_data when high with o_valid
- o_valid  out  1  o_data/o_tag/o_last hold a word
- o_data  out  CNT_W  captured count, or checksum word
- o_tag  out  TAG_W  channel index 0..CH_NUM-1; value CH_NUM marks checksum word
- o_last  out  1  current word is final word of frame
- o_busy  out  1  frame in progress (any state other than IDLE)
- o_done  out  1  one-cycle pulse after final word transferred
- o_drop  out  1  one-cycle pulse: i_snap arrived while busy and was ignored

## Operation
- FSM states: IDLE, SEND, CSUM (only with checksum feature), DONE.
- IDLE: o_valid=0, o_busy=0. i_snap=1 at an edge: capture all CH_NUM counts into snapshot registers at that edge, clear index to 0, go SEND.
- SEND: o_valid=1, o_data=snapshot[index], o_tag=index, o_last=(index==CH_NUM-1) and checksum disabled. Transfer occurs at an edge with o_valid & i_ready. On transfer: if index<CH_NUM-1, increment index; else go CSUM (enabled) or DONE.
- CSUM: o_valid=1, o_data=XOR of all CH_NUM snapshot words, o_tag=CH_NUM, o_last=1. On transfer, go DONE.
- DONE: o_valid=0, o_done=1, o_busy=1 for exactly one cycle, then IDLE.
- Outputs are registered. While o_valid=1 and i_ready=0, o_data/o_tag/o_last hold stable and o_valid does not drop.
- Snapshot is frozen for the whole frame; live count changes after capture never appear in the frame.
- i_snap in SEND/CSUM/DONE: ignored, o_drop pulses the following cycle; frame unaffected. Held-high i_snap in IDLE starts one frame; a new frame starts only on the first IDLE cycle after DONE.
- Index counter is $clog2(CH_NUM) bits and never wraps within a frame.
- Reset (i_rst_n=0 at an edge): state IDLE, index 0, snapshot 0, all outputs 0. Reset mid-frame aborts the frame with no o_done; takes priority over i_snap and handshake.

## Timing
- i_snap sampled at edge N: o_valid=1 with tag 0 from cycle after N.
- i_ready held high: one word per cycle; tags 0..CH_NUM-1 on consecutive cycles (then checksum word).
- Final transfer at edge M: o_valid=0 and o_done=1 in cycle after M; o_busy=0 one cycle later; earliest next capture at edge M+2.
- Full frame, ready always high: CH_NUM cycles valid (CH_NUM+1 with checksum), plus 1 DONE cycle.
- No combinational path from i_ready to any output.

## Configuration
- Macro PULSE_SCAN_CSUM_EN.
- Defined: CSUM state compiled in; frame is CH_NUM count words plus one XOR checksum word (tag CH_NUM, o_last on it).
- Undefined: CSUM state and XOR logic absent; frame is CH_NUM words, o_last on tag CH_NUM-1; o_tag never equals CH_NUM.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles with i_snap=0; i_snap during reset ignored.
- Counts channel k = 0x1000+k, i_snap 1 cycle, i_ready=1: tags 0..15 on consecutive cycles, data 0x1000..0x100F, o_last on tag 15 (or checksum word 0x0000 with PULSE_SCAN_CSUM_EN), then o_done one cycle.
- Change all live counts to 0xFFFF one cycle after capture: streamed data still 0x1000+k.
- i_ready toggling 1-of-3 cycles with random pattern: every word held stable until accepted, no word lost or duplicated, order 0..15.
- i_snap pulsed at tag 5 and in DONE cycle: o_drop pulses twice, only one frame output; i_snap one cycle after o_done starts new frame.
- i_rst_n low at tag 8: next cycle all outputs 0, no o_done; following i_snap yields complete frame from tag 0.
